sam_mem_responder: RTL and testbench

//  Memory-side responder for the SAM CPU bus (ADDRESS_BUS/REQUEST/RW/WAIT/DATA_BUS).

---
 rtl/sam_mem_responder.sv | 137 +++++++++++++
 tb/tb_sam_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sam_mem_responder.sv
// rtl/sam_mem_responder.sv - SAM CPU bus memory responder with programmable wait states
//
// Purpose:
//   Serves one read or write per CPU request. WAIT stalls the CPU while the
//   access is pending. The access runs against an internal RAM of 16-bit words.
//   The request fields are captured when the request is accepted, so the CPU
//   may change the bus while it is stalled without affecting the access.
//
// Ports:
//   clk        in   1      system clock, all state on posedge
//   rst_n      in   1      asynchronous active-low reset (RAM is not cleared)
//   addr_bus   in   16     byte address; word index = addr_bus[IDX_W:1]
//   request    in   1      access request, held until wait_o is seen low
//   rw         in   1      1 = read, 0 = write
//   data_in    in   16     write data
//   data_out   out  16     read data, held until the next completed access
//   wait_o     out  1      stall while an accepted request is incomplete
//   err_o      out  1      last completed access was misaligned or out of range
//   load_en    in   1      preload strobe, honoured only in IDLE
//   load_addr  in   IDX_W  preload word index
//   load_data  in   16     preload data
module sam_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int IDX_W       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      addr_bus,
  input  logic             request,
  input  logic             rw,
  input  logic [15:0]      data_in,
  output logic [15:0]      data_out,
  output logic             wait_o,
  output logic             err_o,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [15:0]      load_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [15:0]      lat_addr;
  logic [15:0]      lat_wdata;
  logic             lat_rw;
  logic [15:0]      ram [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             complete;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [15:0]      ram_wdata;

  assign idx      = lat_addr[IDX_W:1];
  assign addr_err = lat_addr[0] | ({1'b0, lat_addr[15:1]} >= 16'(DEPTH));
  // The access fires on the edge that leaves BUSY with the count exhausted.
  // A dropped request takes priority and aborts the access instead.
  assign complete = (state == S_BUSY) && request && (cnt == 4'd0);

  // Combinational so WAIT is already high in the cycle the request rises.
  assign wait_o = request & (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      data_out  <= 16'h0000;
      err_o     <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_rw    <= 1'b0;
      lat_wdata <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            lat_addr  <= addr_bus;
            lat_rw    <= rw;
            lat_wdata <= data_in;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!request) begin
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_DONE;
            if (addr_err) begin
              data_out <= 16'h0000;
              err_o    <= 1'b1;
            end else begin
              err_o <= 1'b0;
              if (lat_rw) begin
                data_out <= ram[idx];
              end
            end
          end
        end
        S_DONE: begin
          // A request held high here is never re-accepted; it must drop first.
          if (!request) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Preload and CPU write are mutually exclusive by state (IDLE vs BUSY).
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = lat_wdata;
    if ((state == S_IDLE) && load_en) begin
      ram_we    = 1'b1;
      ram_waddr = load_addr;
      ram_wdata = load_data;
    end else if (complete && !lat_rw && !addr_err) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_sam_mem_responder.sv
// tb/tb_sam_mem_responder.sv - self-checking bench for sam_mem_responder (WAIT_CYCLES 2 and 0)
module tb_sam_mem_responder;
  localparam int DEPTH = 256;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      addr_bus = 16'h0000;
  logic             request = 1'b0;
  logic             rw = 1'b0;
  logic [15:0]      data_in = 16'h0000;
  logic             load_en = 1'b0;
  logic [IDX_W-1:0] load_addr = '0;
  logic [15:0]      load_data = 16'h0000;

  // Index 0: WAIT_CYCLES=2 instance, index 1: WAIT_CYCLES=0 instance.
  logic [15:0] dout [2];
  logic        wt   [2];
  logic        er   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sam_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .request(request), .rw(rw),
    .data_in(data_in), .data_out(dout[0]), .wait_o(wt[0]), .err_o(er[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  sam_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .request(request), .rw(rw),
    .data_in(data_in), .data_out(dout[1]), .wait_o(wt[1]), .err_o(er[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Model: "age" is how many edges the current request has been seen high.
  // Age 0 means the responder is idle; the access completes on the edge that
  // takes age to WAIT_CYCLES+2, and wait is high while age is below that.
  int          age    [2] = '{0, 0};
  int          n_acc  [2] = '{0, 0};
  logic [15:0] l_addr [2];
  logic [15:0] l_data [2];
  logic        l_rw   [2];
  logic [15:0] mem    [2][DEPTH];
  logic [15:0] exp_dout [2] = '{16'h0000, 16'h0000};
  logic        exp_err  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        age[i]      <= 0;
        exp_dout[i] <= 16'h0000;
        exp_err[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load_en && age[i] == 0) mem[i][load_addr] <= load_data;
        if (!request) begin
          age[i] <= 0;
        end else begin
          if (age[i] == 0) begin
            l_addr[i] <= addr_bus;
            l_rw[i]   <= rw;
            l_data[i] <= data_in;
          end
          if (age[i] + 1 == wc(i) + 2) begin
            n_acc[i] <= n_acc[i] + 1;
            if (l_addr[i][0] || (l_addr[i] >> 1) >= 16'(DEPTH)) begin
              exp_dout[i] <= 16'h0000;
              exp_err[i]  <= 1'b1;
            end else if (l_rw[i]) begin
              exp_dout[i] <= mem[i][8'(l_addr[i] >> 1)];
              exp_err[i]  <= 1'b0;
            end else begin
              mem[i][8'(l_addr[i] >> 1)] <= l_data[i];
              exp_err[i] <= 1'b0;
            end
          end
          age[i] <= age[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_cycle(input int cyc);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc%0d_wait_dut%0d", cyc, i), {15'd0, wt[i]},
          {15'd0, request && (age[i] < wc(i) + 2)});
      chk($sformatf("cyc%0d_data_dut%0d", cyc, i), dout[i], exp_dout[i]);
      chk($sformatf("cyc%0d_err_dut%0d", cyc, i), {15'd0, er[i]}, {15'd0, exp_err[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [IDX_W-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Holds request for 'hold' cycles, counting cycles with wait high, then drops it for one cycle.
  task automatic access(input logic [15:0] a, input logic r, input logic [15:0] d,
                        input int hold, input bit ld, output int w0, output int w1);
    addr_bus = a; rw = r; data_in = d; request = 1'b1;
    if (ld) begin
      load_en = 1'b1; load_addr = a[8:1]; load_data = d;
    end
    w0 = 0; w1 = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      w0 += int'(wt[0]);
      w1 += int'(wt[1]);
      step();
      load_en = 1'b0;
    end
    request = 1'b0;
    step();
  endtask

  task automatic chk_both(input string nm, input logic [15:0] d, input logic e);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_data_dut%0d", nm, i), dout[i], d);
      chk($sformatf("%s_err_dut%0d", nm, i), {15'd0, er[i]}, {15'd0, e});
    end
  endtask

  initial begin
    int w0, w1, n0;
    fork
      begin
        int cyc = 0;
        forever begin
          @(negedge clk);
          cmp_cycle(cyc);
          cyc++;
        end
      end
    join_none

    repeat (2) step();
    chk_both("reset", 16'h0000, 1'b0);
    chk("reset_wait_dut0", {15'd0, wt[0]}, 16'd0);
    rst_n = 1'b1;
    step();

    preload(8'd3, 16'h1234);
    preload(8'd8, 16'h5A5A);
    preload(8'd0, 16'h0F0F);
    preload(8'd16, 16'h2020);

    // T1: read word 3, stall length per instance
    access(16'h0006, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk("t1_wait_cycles_w2", 16'(w0), 16'd4);
    chk("t1_wait_cycles_w0", 16'(w1), 16'd2);
    chk_both("t1_read", 16'h1234, 1'b0);

    // T2: aborted write leaves word 8 alone, then a real write lands
    access(16'h0010, 1'b0, 16'hDEAD, 1, 1'b0, w0, w1);
    access(16'h0010, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t2_after_abort", 16'h5A5A, 1'b0);
    access(16'h0010, 1'b0, 16'hBEEF, 5, 1'b0, w0, w1);
    chk_both("t2_write_holds_data", 16'h5A5A, 1'b0);
    access(16'h0010, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t2_readback", 16'hBEEF, 1'b0);

    // Preload and request on the same idle edge
    access(16'h0040, 1'b1, 16'h7777, 5, 1'b1, w0, w1);
    chk_both("same_edge_preload", 16'h7777, 1'b0);

    // Last valid word
    access(16'h01FE, 1'b0, 16'hC0DE, 5, 1'b0, w0, w1);
    access(16'h01FE, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("last_word", 16'hC0DE, 1'b0);

    // T3: misaligned and out-of-range
    access(16'h0005, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t3_odd", 16'h0000, 1'b1);
    access(16'h0006, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t3_recover", 16'h1234, 1'b0);
    access(16'h0200, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t3_range", 16'h0000, 1'b1);
    access(16'h0200, 1'b0, 16'hFFFF, 5, 1'b0, w0, w1);
    access(16'h0000, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t3_ram_unmodified", 16'h0F0F, 1'b0);

    // T4: request held through DONE, then re-raised after one low cycle
    n0 = n_acc[0];
    access(16'h0006, 1'b1, 16'h0000, 7, 1'b0, w0, w1);
    chk("t4_held_wait_w2", 16'(w0), 16'd4);
    chk("t4_held_wait_w0", 16'(w1), 16'd2);
    chk("t4_single_access", 16'(n_acc[0] - n0), 16'd1);
    access(16'h0040, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk("t4_rerun_wait_w2", 16'(w0), 16'd4);
    chk_both("t4_rerun", 16'h7777, 1'b0);

    // T5: reset in the middle of a write to word 16
    addr_bus = 16'h0020; rw = 1'b0; data_in = 16'hABCD; request = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("t5_async_reset", 16'h0000, 1'b0);
    chk("t5_wait_eq_request", {15'd0, wt[0]}, 16'd1);
    request = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    access(16'h0020, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t5_old_value", 16'h2020, 1'b0);

    // T6: bus changes while stalled do not alter the latched read
    addr_bus = 16'h0006; rw = 1'b1; request = 1'b1;
    step();
    addr_bus = 16'h0010; rw = 1'b0; data_in = 16'h9999;
    repeat (4) step();
    request = 1'b0;
    step();
    chk_both("t6_latched_read", 16'h1234, 1'b0);
    access(16'h0010, 1'b1, 16'h0000, 5, 1'b0, w0, w1);
    chk_both("t6_no_stray_write", 16'hBEEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
